mvb_split_items: RTL

Splits every item of one MVB stream into two narrower items and sends them on two independent MVB outputs. It is the counterpart of the MVB item merger and sits directly downstream of it. It takes the concatenated items produced there and hands the two halves back to consumers that stall independently. Each input word is registered once and released upstream only when both outputs have taken their half. This is fork semantics with per-branch completion tracking.

---
 rtl/mvb_split_items.sv | 85 ++++++++
 1 files changed

// File: rtl/mvb_split_items.sv
// mvb_split_items: forks every MVB item into its low part (TX0) and high part (TX1),
// tracking completion per branch. Optional macro: MVB_SPLIT_ITEMS_DROP_EMPTY_EN.
module mvb_split_items #(
    parameter int ITEMS       = 4,
    parameter int ITEM_WIDTH0 = 8,
    parameter int ITEM_WIDTH1 = 8
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic [ITEMS*(ITEM_WIDTH0+ITEM_WIDTH1)-1:0] RX_DATA,
    input  logic [ITEMS-1:0]                   RX_VLD,
    input  logic                               RX_SRC_RDY,
    output logic                               RX_DST_RDY,
    output logic [ITEMS*ITEM_WIDTH0-1:0]       TX0_DATA,
    output logic [ITEMS-1:0]                   TX0_VLD,
    output logic                               TX0_SRC_RDY,
    input  logic                               TX0_DST_RDY,
    output logic [ITEMS*ITEM_WIDTH1-1:0]       TX1_DATA,
    output logic [ITEMS-1:0]                   TX1_VLD,
    output logic                               TX1_SRC_RDY,
    input  logic                               TX1_DST_RDY
);

    localparam int IW = ITEM_WIDTH0 + ITEM_WIDTH1;

    logic [ITEMS*IW-1:0] data_r;
    logic [ITEMS-1:0]    vld_r;
    logic                pend0_r;
    logic                pend1_r;
    logic                done0_s;
    logic                done1_s;
    logic                free_s;
    logic                rx_xfer_s;
    logic                load_pend_s;

`ifdef MVB_SPLIT_ITEMS_DROP_EMPTY_EN
    // A word without any valid item is consumed but never presented downstream.
    assign load_pend_s = |RX_VLD;
`else
    assign load_pend_s = 1'b1;
`endif

    // Per-branch completion and the "register may take a new word" condition.
    always_comb begin
        done0_s    = pend0_r & TX0_DST_RDY;
        done1_s    = pend1_r & TX1_DST_RDY;
        free_s     = (~pend0_r | done0_s) & (~pend1_r | done1_s);
        RX_DST_RDY = free_s & ~RESET;
        rx_xfer_s  = RX_SRC_RDY & RX_DST_RDY;
    end

    // Word register and pending flags; a new word loads on the edge the old one completes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_r  <= {(ITEMS*IW){1'b0}};
            vld_r   <= {ITEMS{1'b0}};
            pend0_r <= 1'b0;
            pend1_r <= 1'b0;
        end else if (rx_xfer_s) begin
            data_r  <= RX_DATA;
            vld_r   <= RX_VLD;
            pend0_r <= load_pend_s;
            pend1_r <= load_pend_s;
        end else begin
            pend0_r <= pend0_r & ~done0_s;
            pend1_r <= pend1_r & ~done1_s;
        end
    end

    // Slice each registered item into its low and high halves.
    always_comb begin
        TX0_DATA = {(ITEMS*ITEM_WIDTH0){1'b0}};
        TX1_DATA = {(ITEMS*ITEM_WIDTH1){1'b0}};
        for (int i = 0; i < ITEMS; i++) begin
            TX0_DATA[i*ITEM_WIDTH0 +: ITEM_WIDTH0] = data_r[i*IW +: ITEM_WIDTH0];
            TX1_DATA[i*ITEM_WIDTH1 +: ITEM_WIDTH1] = data_r[i*IW+ITEM_WIDTH0 +: ITEM_WIDTH1];
        end
    end

    assign TX0_VLD     = vld_r;
    assign TX1_VLD     = vld_r;
    assign TX0_SRC_RDY = pend0_r;
    assign TX1_SRC_RDY = pend1_r;

endmodule
